// File: rtl/stopwatch_timebase_regfile.sv
// Stopwatch time base: a synchronous BCD mm:ss.cc counter with registered carries,
// plus a lap-record register file that stores snapshots of the live time value.
module stopwatch_timebase_regfile #(
   parameter int ADDR_W  = 4,
   parameter int MIN_MAX = 59
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              count_en,
   input  logic              rec_we,
   input  logic [ADDR_W-1:0] rec_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [23:0]       time_bcd,
   output logic [23:0]       rd_data,
   output logic              sec_carry,
   output logic              min_carry,
   output logic              wrap
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [3:0] MIN_T = 4'(MIN_MAX / 10);
   localparam logic [3:0] MIN_U = 4'(MIN_MAX % 10);

   logic [3:0] cc_u, cc_t, s_u, s_t, m_u, m_t;
   logic       cc_wrap, s_wrap, m_wrap;
   logic [23:0] rec_mem [DEPTH];

   // All wrap conditions are decoded from the pre-edge value so every stage moves on the same edge.
   assign cc_wrap = count_en && (cc_u == 4'd9) && (cc_t == 4'd9);
   assign s_wrap  = cc_wrap && (s_u == 4'd9) && (s_t == 4'd5);
   assign m_wrap  = s_wrap && (m_u == MIN_U) && (m_t == MIN_T);

   assign time_bcd = {m_t, m_u, s_t, s_u, cc_t, cc_u};

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cc_u      <= 4'd0;
         cc_t      <= 4'd0;
         s_u       <= 4'd0;
         s_t       <= 4'd0;
         m_u       <= 4'd0;
         m_t       <= 4'd0;
         sec_carry <= 1'b0;
         min_carry <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         sec_carry <= cc_wrap;
         min_carry <= s_wrap;
         wrap      <= m_wrap;
         if (count_en) begin
            if (cc_u >= 4'd9) begin
               cc_u <= 4'd0;
               cc_t <= (cc_t >= 4'd9) ? 4'd0 : cc_t + 4'd1;
            end else begin
               cc_u <= cc_u + 4'd1;
            end
         end
         if (cc_wrap) begin
            if (s_u >= 4'd9) begin
               s_u <= 4'd0;
               s_t <= (s_t >= 4'd5) ? 4'd0 : s_t + 4'd1;
            end else begin
               s_u <= s_u + 4'd1;
            end
         end
         if (s_wrap) begin
            if (m_wrap) begin
               m_u <= 4'd0;
               m_t <= 4'd0;
            end else if (m_u >= 4'd9) begin
               m_u <= 4'd0;
               m_t <= m_t + 4'd1;
            end else begin
               m_u <= m_u + 4'd1;
            end
         end
      end
   end

   // Read samples the array before this edge's write lands, giving read-before-write.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= 24'd0;
         for (int i = 0; i < DEPTH; i++) begin
            rec_mem[i] <= 24'd0;
         end
      end else begin
         rd_data <= rec_mem[rd_addr];
         if (rec_we) begin
            rec_mem[rec_addr] <= time_bcd;
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_timebase_regfile.sv
// Scoreboard bench for stopwatch_timebase_regfile: a centisecond-integer model predicts
// every output cycle; a negedge monitor compares, directed checks cover the key scenarios.
module tb_stopwatch_timebase_regfile;

   localparam int ADDR_W  = 4;
   localparam int MIN_MAX = 10;
   localparam int PERIOD  = (MIN_MAX + 1) * 6000;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              clear = 1'b0;
   logic              count_en = 1'b0;
   logic              rec_we = 1'b0;
   logic [ADDR_W-1:0] rec_addr = '0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic [23:0]       time_bcd;
   logic [23:0]       rd_data;
   logic              sec_carry, min_carry, wrap;

   stopwatch_timebase_regfile #(.ADDR_W(ADDR_W), .MIN_MAX(MIN_MAX)) dut (
      .clk(clk), .reset(reset), .clear(clear), .count_en(count_en),
      .rec_we(rec_we), .rec_addr(rec_addr), .rd_addr(rd_addr),
      .time_bcd(time_bcd), .rd_data(rd_data),
      .sec_carry(sec_carry), .min_carry(min_carry), .wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] tm;
      logic [23:0] rd;
      logic        sc;
      logic        mc;
      logic        wr;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          sc_cnt = 0, mc_cnt = 0, wr_cnt = 0;
   int          t_m = 0;
   logic [23:0] mem_m [2**ADDR_W];
   logic [23:0] rd_m = '0;

   function automatic logic [23:0] to_bcd(input int t);
      int cs, s, m;
      cs = t % 100;
      s  = (t / 100) % 60;
      m  = t / 6000;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
   endfunction

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one clock of stimulus and advance the reference model across that edge.
   task automatic cycle(input logic rst, input logic clr, input logic en, input logic we,
                        input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] ra);
      exp_t e;
      reset = rst; clear = clr; count_en = en; rec_we = we; rec_addr = wa; rd_addr = ra;
      @(posedge clk);
      e.sc = 1'b0; e.mc = 1'b0; e.wr = 1'b0;
      if (rst) begin
         t_m  = 0;
         rd_m = '0;
         for (int i = 0; i < 2**ADDR_W; i++) mem_m[i] = '0;
      end else begin
         rd_m = mem_m[ra];
         if (we) mem_m[wa] = to_bcd(t_m);
         if (clr) begin
            t_m = 0;
         end else if (en) begin
            e.sc = (t_m % 100) == 99;
            e.mc = (t_m % 6000) == 5999;
            e.wr = t_m == PERIOD - 1;
            t_m  = (t_m + 1) % PERIOD;
         end
      end
      e.tm = to_bcd(t_m);
      e.rd = rd_m;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic tick();
      cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("time_bcd", time_bcd, e.tm);
         chk("rd_data", rd_data, e.rd);
         chk("sec_carry", 24'(sec_carry), 24'(e.sc));
         chk("min_carry", 24'(min_carry), 24'(e.mc));
         chk("wrap", 24'(wrap), 24'(e.wr));
      end
      if (sec_carry === 1'b1) sc_cnt++;
      if (min_carry === 1'b1) mc_cnt++;
      if (wrap === 1'b1) wr_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd1, '0);
      for (int i = 0; i < 2**ADDR_W; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 4'(i));
      settle();
      chk("reset_time", time_bcd, 24'h000000);
      chk("reset_rd15", rd_data, 24'h000000);

      sc_cnt = 0; mc_cnt = 0;
      repeat (100) tick();
      settle();
      chk("t100_time", time_bcd, 24'h000100);
      chk("t100_sc_once", 24'(sc_cnt), 24'd1);

      repeat (5899) tick();
      settle();
      chk("t5999_time", time_bcd, 24'h005999);
      chk("t5999_no_mc", 24'(mc_cnt), 24'd0);
      tick();
      settle();
      chk("t6000_time", time_bcd, 24'h010000);
      chk("t6000_mc_once", 24'(mc_cnt), 24'd1);

      cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      repeat (1234) tick();
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, '0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd3);
      chk("lap_addr3", rd_data, 24'h001234);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd2);
      chk("lap_addr2_untouched", rd_data, 24'h000000);

      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, '0);
      repeat (10) tick();
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd5);
      chk("rbw_old", rd_data, 24'h001235);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd5);
      chk("rbw_new", rd_data, 24'h001245);

      repeat (50) tick();
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, '0);
      chk("clear_time", time_bcd, 24'h000000);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd3);
      chk("clear_keeps_addr3", rd_data, 24'h001234);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd7);
      chk("write_during_clear", rd_data, 24'h001295);

      repeat (1500) begin
         cycle(1'b0, ($urandom % 64) == 0, ($urandom % 4) != 0, ($urandom % 8) == 0,
               4'($urandom), 4'($urandom));
      end

      cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      settle();
      wr_cnt = 0;
      repeat (PERIOD - 1) tick();
      settle();
      chk("pre_wrap_time", time_bcd, 24'h105999);
      chk("pre_wrap_none", 24'(wr_cnt), 24'd0);
      tick();
      settle();
      chk("wrap_time", time_bcd, 24'h000000);
      chk("wrap_once", 24'(wr_cnt), 24'd1);

      cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, '0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd9);
      chk("reset_blocks_write", rd_data, 24'h000000);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd3);
      chk("reset_clears_addr3", rd_data, 24'h000000);

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_timebase_regfile.md
Name: stopwatch_timebase_regfile

Overview:
- Single-clock stopwatch core with three pieces:
  - a BCD time counter, mm:ss.cc in centiseconds, advanced by a one-cycle enable;
  - seconds and minutes cascade stages driven by internal carries;
  - a lap-record register file that captures the current time value into an addressed slot and reads slots back.
- Sits between the control FSM / 100 Hz tick generator and the display multiplexer.
- Replaces the earlier ripple-clocked counters and register file with a fully synchronous, enable-based equivalent.

Parameters:
- ADDR_W, 4: register-file address width; depth = 2**ADDR_W entries.
- MIN_MAX, 59: terminal minute value; the minutes stage wraps after it.

Ports:
- clk, input, 1: single system clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high. Clears counters, all register-file entries, and all registered outputs.
- clear, input, 1: synchronous clear of the time counters only; the register file is kept.
- count_en, input, 1: one-cycle centisecond tick, already gated by run/not-paused.
- rec_we, input, 1: write current time_bcd into entry rec_addr.
- rec_addr, input, ADDR_W: write address.
- rd_addr, input, ADDR_W: read address.
- time_bcd, output, 24: live time value.
  - [23:20] minute tens, [19:16] minute units;
  - [15:12] second tens, [11:8] second units;
  - [7:4] centisecond tens, [3:0] centisecond units.
- rd_data, output, 24: registered read data.
- sec_carry, output, 1: one-cycle pulse when centiseconds wrap 99->00.
- min_carry, output, 1: one-cycle pulse when seconds wrap 59->00.
- wrap, output, 1: one-cycle pulse when the full count wraps MIN_MAX:59.99 -> 00:00.00.

Behaviour:
- Reset (reset=1 at a clock edge):
  - time_bcd = 0, rd_data = 0, all carries/wrap = 0;
  - all 2**ADDR_W entries = 0;
  - reset overrides clear, count_en and rec_we.
- Priority on counters: reset > clear > count_en. While clear=1, counters go to 0 and carries stay 0.
- Centisecond stage:
  - BCD units 0-9, tens 0-9;
  - increments only on count_en;
  - on 99 with count_en: goes to 00 and asserts sec_carry for that edge's output cycle.
- Seconds stage:
  - increments only when the centisecond stage wraps in the same cycle;
  - units 0-9, tens 0-5;
  - 59 -> 00 asserts min_carry.
- Minutes stage:
  - increments on a seconds wrap;
  - counts 00..MIN_MAX in BCD, then wraps to 00;
  - the full wrap asserts wrap.
- Counting is one cycle per enabled tick: every stage update happens at the same edge, with no ripple latency.
- Carry/wrap outputs are registered and valid in the cycle after the triggering edge. They are high for exactly one cycle and never high without count_en having been high on the previous edge.
- BCD digits never hold values above 9; tens digits of seconds never hold values above 5.
- Register file write:
  - on rec_we, entry[rec_addr] <= time_bcd value present before that edge's increment;
  - a simultaneous count_en increment is not captured.
- Register file read:
  - rd_data <= entry[rd_addr] every clock; one-cycle latency;
  - read-before-write: same address written and read in one cycle returns old contents, new contents on the next cycle.
- Writes during clear store the pre-clear time value.
- No other entry is disturbed by a write.

Test Plan:
- Reset, then read every address -> time_bcd = 24'h000000; rd_data = 0 for all 16 entries.
- 100 count_en pulses from 0:
  - time_bcd = 24'h000100;
  - sec_carry pulses exactly once, on the 100th tick.
- Preload via 5999 ticks to 00:59.99, then one tick -> time_bcd = 24'h010000, min_carry pulses once.
- Count to 59:59.99 (359999 ticks), one more tick -> time_bcd = 24'h000000, wrap pulses once.
- Lap capture:
  - at 00:12.34 assert rec_we with rec_addr=3 together with count_en;
  - next cycle, rd_addr=3 -> rd_data = 24'h001234 (not 001235);
  - address 2 still 0.
- Same-cycle read/write address 5 -> rd_data = old value, then new value a cycle later.
- Clear mid-count with count_en=1:
  - time_bcd = 0, register contents retained;
  - reset asserted with rec_we=1 -> entry not written, all zero.
